// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Definitions shared by the frame buffer and the net wrapper:
//   - default word widths and word counts
//   - frame buffer FSM state encoding
//   - helper that sizes the shared counters
// ---------------------------------------------------------------------------
package nn_pkg;

    localparam int NN_IN_WIDTH  = 32;
    localparam int NN_N_INPUTS  = 784;
    localparam int NN_OUT_WIDTH = 32;
    localparam int NN_N_OUTPUTS = 10;
    localparam int NN_READ_GAP  = 4;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // One width serves wr_cnt, rd_cnt and gap_cnt. It must hold the largest
    // terminal count, which is N_INPUTS-1, N_OUTPUTS-1 or READ_GAP.
    function automatic int cnt_width(input int n_inputs, input int n_outputs,
                                     input int read_gap);
        int m;
        m = n_inputs;
        if (n_outputs > m)    m = n_outputs;
        if (read_gap + 1 > m) m = read_gap + 1;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/nn_result_drain.sv
// ---------------------------------------------------------------------------
// nn_result_drain
// Holds the packed result from the net core. It hands the result out one word
// at a time and waits READ_GAP idle cycles after each pop.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture result and start draining (top asserts it in S_WAIT)
//   result       packed result, word k at [k*OUT_WIDTH +: OUT_WIDTH]
//   i_r_stb      read strobe (pop)
//   o_r_data     current word, 0 when o_r_valid is low
//   o_r_valid    o_r_data can be popped this cycle
//   last_pop     the final word of the frame is popped this cycle
// ---------------------------------------------------------------------------
module nn_result_drain
    import nn_pkg::*;
#(
    parameter int OUT_WIDTH = NN_OUT_WIDTH,
    parameter int N_OUTPUTS = NN_N_OUTPUTS,
    parameter int READ_GAP  = NN_READ_GAP,
    parameter int CNT_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [OUT_WIDTH*N_OUTPUTS-1:0] result,
    input  logic                           i_r_stb,
    output logic [OUT_WIDTH-1:0]           o_r_data,
    output logic                           o_r_valid,
    output logic                           last_pop
);

    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(N_OUTPUTS - 1);
    localparam logic [CNT_W-1:0] GAP     = CNT_W'(READ_GAP);

    logic                           active;
    logic [CNT_W-1:0]               rd_cnt;
    logic [CNT_W-1:0]               gap_cnt;
    logic [OUT_WIDTH*N_OUTPUTS-1:0] result_q;
    logic                           pop;

    assign o_r_valid = active && (gap_cnt == '0);
    assign pop       = i_r_stb && o_r_valid;
    assign last_pop  = pop && (rd_cnt == LAST_RD);
    assign o_r_data  = o_r_valid ? result_q[int'(rd_cnt)*OUT_WIDTH +: OUT_WIDTH] : '0;

    // NOTE: data storage has no reset. The active flag decides whether the
    // stored data is used, so clearing the storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (!rst && load) result_q <= result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            rd_cnt  <= '0;
            gap_cnt <= '0;
        end else if (load) begin
            active  <= 1'b1;
            rd_cnt  <= '0;
            gap_cnt <= '0;
        end else if (active) begin
            if (pop) begin
                gap_cnt <= GAP;
                if (last_pop) begin
                    active <= 1'b0;
                    rd_cnt <= '0;
                end else begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nn_frame_buffer.sv
// ---------------------------------------------------------------------------
// nn_frame_buffer
// Collects N_INPUTS words into a packed image and pulses o_image_valid once
// per frame. It captures the net core result, drains the result words with
// pacing, and then accepts the next frame.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_w_stb/i_w_data/o_w_ready   write path
//   o_image, o_image_valid       packed image and start pulse to the net core
//   i_result, i_result_valid     packed result from the net core
//   i_r_stb, o_r_data, o_r_valid paced read path
//   o_busy          high outside S_LOAD
//   o_overflow      sticky; set when a write arrives while o_w_ready is low
// ---------------------------------------------------------------------------
module nn_frame_buffer
    import nn_pkg::*;
#(
    parameter int IN_WIDTH  = NN_IN_WIDTH,
    parameter int N_INPUTS  = NN_N_INPUTS,
    parameter int OUT_WIDTH = NN_OUT_WIDTH,
    parameter int N_OUTPUTS = NN_N_OUTPUTS,
    parameter int READ_GAP  = NN_READ_GAP
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_w_stb,
    input  logic [IN_WIDTH-1:0]            i_w_data,
    output logic                           o_w_ready,
    output logic [IN_WIDTH*N_INPUTS-1:0]   o_image,
    output logic                           o_image_valid,
    input  logic [OUT_WIDTH*N_OUTPUTS-1:0] i_result,
    input  logic                           i_result_valid,
    input  logic                           i_r_stb,
    output logic [OUT_WIDTH-1:0]           o_r_data,
    output logic                           o_r_valid,
    output logic                           o_busy,
    output logic                           o_overflow
);

    localparam int               CNT_W   = cnt_width(N_INPUTS, N_OUTPUTS, READ_GAP);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(N_INPUTS - 1);

    state_t                       state;
    logic [CNT_W-1:0]             wr_cnt;
    logic [IN_WIDTH*N_INPUTS-1:0] image_q;
    logic                         result_load;
    logic                         last_pop;

    // A result that arrives in any state other than S_WAIT is dropped.
    assign result_load = (state == S_WAIT) && i_result_valid;
    assign o_image     = image_q;

    // The image is written only in S_LOAD, so it stays stable from S_START
    // until the first write of the next frame.
    always_ff @(posedge clk) begin
        if (!rst && state == S_LOAD && i_w_stb)
            image_q[int'(wr_cnt)*IN_WIDTH +: IN_WIDTH] <= i_w_data;
    end

    // NOTE: every state and output register is updated with non-blocking
    // assignments. All of them then take values computed from the same
    // pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_LOAD;
            wr_cnt        <= '0;
            o_w_ready     <= 1'b1;
            o_image_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_image_valid <= 1'b0;
            if (i_w_stb && !o_w_ready) o_overflow <= 1'b1;

            case (state)
                S_LOAD: begin
                    if (i_w_stb) begin
                        if (wr_cnt == LAST_WR) begin
                            wr_cnt        <= '0;
                            state         <= S_START;
                            o_w_ready     <= 1'b0;
                            o_image_valid <= 1'b1;
                            o_busy        <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + CNT_W'(1);
                        end
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT:  if (i_result_valid) state <= S_DRAIN;
                S_DRAIN: begin
                    if (last_pop) begin
                        state     <= S_LOAD;
                        o_w_ready <= 1'b1;
                        o_busy    <= 1'b0;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    nn_result_drain #(
        .OUT_WIDTH (OUT_WIDTH),
        .N_OUTPUTS (N_OUTPUTS),
        .READ_GAP  (READ_GAP),
        .CNT_W     (CNT_W)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
        .load      (result_load),
        .result    (i_result),
        .i_r_stb   (i_r_stb),
        .o_r_data  (o_r_data),
        .o_r_valid (o_r_valid),
        .last_pop  (last_pop)
    );

endmodule

// File: tb/tb_nn_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_nn_frame_buffer
// Scoreboard bench. The stimulus tasks push the expected images and result
// words into queues. Monitors on the falling edge pop from those queues and
// compare whenever a DUT presents output. It uses a small instance (4/3/2)
// and a default instance (784/10/4).
// ---------------------------------------------------------------------------
module tb_nn_frame_buffer;

    localparam int W   = 32;
    localparam int NI  = 4;
    localparam int NO  = 3;
    localparam int GAP = 2;
    localparam int DNI = 784;
    localparam int DNO = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // small instance
    logic          w_stb, w_ready, image_valid, result_valid, r_stb, r_valid, busy, overflow;
    logic [W-1:0]  w_data, r_data;
    logic [W*NI-1:0] image;
    logic [W*NO-1:0] result;

    // default instance
    logic           d_w_stb, d_w_ready, d_image_valid, d_result_valid, d_r_stb, d_r_valid, d_busy, d_overflow;
    logic [W-1:0]   d_w_data, d_r_data;
    logic [W*DNI-1:0] d_image;
    logic [W*DNO-1:0] d_result;

    nn_frame_buffer #(.IN_WIDTH(W), .N_INPUTS(NI), .OUT_WIDTH(W), .N_OUTPUTS(NO), .READ_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .i_w_stb(w_stb), .i_w_data(w_data), .o_w_ready(w_ready),
        .o_image(image), .o_image_valid(image_valid), .i_result(result), .i_result_valid(result_valid),
        .i_r_stb(r_stb), .o_r_data(r_data), .o_r_valid(r_valid), .o_busy(busy), .o_overflow(overflow));

    nn_frame_buffer dut_d (
        .clk(clk), .rst(rst), .i_w_stb(d_w_stb), .i_w_data(d_w_data), .o_w_ready(d_w_ready),
        .o_image(d_image), .o_image_valid(d_image_valid), .i_result(d_result), .i_result_valid(d_result_valid),
        .i_r_stb(d_r_stb), .o_r_data(d_r_data), .o_r_valid(d_r_valid), .o_busy(d_busy), .o_overflow(d_overflow));

    int checks = 0;
    int errors = 0;

    // reference model: frames as lists of words, results as queues of words
    logic [W-1:0]    part_q[$];
    logic [W*NI-1:0] img_q[$];
    logic [W-1:0]    rd_q[$];
    logic [W*NI-1:0] last_img;
    bit              model_loading = 1'b1;
    bit              model_waiting = 1'b0;
    bit              model_ovf     = 1'b0;
    int              pulses_exp    = 0;
    int              pulses_seen   = 0;

    logic [W*DNI-1:0] d_img_q[$];
    logic [W-1:0]     d_rd_q[$];
    int               d_pulses_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (image_valid) begin
                pulses_seen++;
                if (img_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL image_pulse: unexpected o_image_valid, image %h", image);
                end else begin
                    check("image", image, img_q.pop_front());
                end
            end
            if (r_valid && r_stb) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_pop: unexpected pop, data %h", r_data);
                end else begin
                    check("r_data", r_data, rd_q.pop_front());
                end
            end
            if (!r_valid) check("r_data_idle", r_data, 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (d_image_valid) begin
                d_pulses_seen++;
                checks++;
                if (d_img_q.size() == 0) begin
                    errors++;
                    $display("FAIL d_image_pulse: unexpected o_image_valid");
                end else begin
                    logic [W*DNI-1:0] e;
                    e = d_img_q.pop_front();
                    if (d_image !== e) begin
                        errors++;
                        for (int k = 0; k < DNI; k++)
                            if (d_image[k*W +: W] !== e[k*W +: W]) begin
                                $display("FAIL d_image: word %0d got %h, expected %h", k, d_image[k*W +: W], e[k*W +: W]);
                                break;
                            end
                    end
                end
            end
            if (d_r_valid && d_r_stb) begin
                if (d_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_r_pop: unexpected pop, data %h", d_r_data);
                end else begin
                    check("d_r_data", d_r_data, d_rd_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus (small instance) ----------------
    task automatic write_word(input logic [W-1:0] d);
        w_stb  = 1'b1;
        w_data = d;
        if (model_loading) begin
            part_q.push_back(d);
            if (part_q.size() == NI) begin
                logic [W*NI-1:0] p;
                foreach (part_q[k]) p[k*W +: W] = part_q[k];
                img_q.push_back(p);
                last_img = p;
                part_q.delete();
                model_loading = 1'b0;
                model_waiting = 1'b1;
                pulses_exp++;
            end
        end else begin
            model_ovf = 1'b1;
        end
        tick();
        w_stb = 1'b0;
    endtask

    task automatic write_frame(input logic [W-1:0] words[NI]);
        for (int i = 0; i < NI; i++) write_word(words[i]);
        // one cycle after the last write edge
        check("image_valid_pulse", image_valid, 1);
        check("w_ready_in_start", w_ready, 0);
        check("busy_in_start", busy, 1);
        tick();
        check("image_valid_single", image_valid, 0);
    endtask

    task automatic write_random_frame();
        logic [W-1:0] words[NI];
        foreach (words[k]) words[k] = $urandom;
        write_frame(words);
    endtask

    task automatic give_result(input logic [W-1:0] words[NO]);
        foreach (words[k]) result[k*W +: W] = words[k];
        result_valid = 1'b1;
        if (model_waiting) begin
            foreach (words[k]) rd_q.push_back(words[k]);
            model_waiting = 1'b0;
        end
        tick();
        result_valid = 1'b0;
    endtask

    task automatic give_random_result();
        logic [W-1:0] words[NO];
        foreach (words[k]) words[k] = $urandom;
        give_result(words);
    endtask

    task automatic drain(input bit hold);
        int pops = 0;
        int last = -1;
        int cyc  = 0;
        while (pops < NO && cyc < 200) begin
            r_stb = hold ? 1'b1 : 1'($urandom_range(0, 1));
            if (r_valid && r_stb) begin
                if (hold && last >= 0) check("beat_spacing", cyc - last, GAP + 1);
                last = cyc;
                pops++;
            end
            tick();
            cyc++;
        end
        r_stb = 1'b0;
        if (pops < NO) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pops, expected %0d", pops, NO);
        end
        model_loading = 1'b1;
        check("w_ready_after_drain", w_ready, 1);
        check("busy_after_drain", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] f1[NI];
        logic [W-1:0] r1[NO];

        rst = 1'b1;
        w_stb = 0; w_data = 0; result = '0; result_valid = 0; r_stb = 0;
        d_w_stb = 0; d_w_data = 0; d_result = '0; d_result_valid = 0; d_r_stb = 0;
        repeat (3) tick();

        // reset state
        check("rst_w_ready", w_ready, 1);
        check("rst_image_valid", image_valid, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_data", r_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // 1: fixed frame
        f1 = '{32'h11, 32'h22, 32'h33, 32'h44};
        write_frame(f1);
        check("image_fixed", image, 128'h00000044_00000033_00000022_00000011);

        // 2: result {0xC,0xB,0xA}, read out with the strobe held
        r1 = '{32'hA, 32'hB, 32'hC};
        give_result(r1);
        drain(1'b1);

        // 3: write while waiting -> sticky overflow, image unchanged
        write_random_frame();
        write_word($urandom);
        check("overflow_set", overflow, model_ovf);
        check("image_hold", image, last_img);
        give_random_result();
        drain(1'b0);
        write_random_frame();
        give_random_result();
        drain(1'b1);
        check("overflow_sticky", overflow, model_ovf);

        // 5: result strobe in S_LOAD, read strobe in S_WAIT are ignored
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        check("ignored_result_busy", busy, 0);
        check("ignored_result_w_ready", w_ready, 1);
        check("ignored_result_r_valid", r_valid, 0);
        write_random_frame();
        r_stb = 1'b1;
        repeat (3) tick();
        check("wait_r_valid", r_valid, 0);
        check("wait_busy", busy, 1);
        r_stb = 1'b0;
        give_random_result();
        drain(1'b1);

        // 4: reset after 2 of 4 writes discards the partial frame
        write_word($urandom);
        write_word($urandom);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        part_q.delete();
        model_ovf = 1'b0;
        model_loading = 1'b1;
        check("overflow_cleared", overflow, model_ovf);
        write_random_frame();
        give_random_result();
        drain(1'b0);

        // random frames with random read strobes
        for (int f = 0; f < 4; f++) begin
            write_random_frame();
            repeat ($urandom_range(0, 3)) tick();
            give_random_result();
            drain(f[0]);
        end

        check("pulse_count", pulses_seen, pulses_exp);
        check("img_q_empty", img_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);

        // 6: default parameters, two full frames
        for (int f = 0; f < 2; f++) begin
            logic [W*DNI-1:0] dimg;
            int pops;
            int cyc;
            for (int i = 0; i < DNI; i++) begin
                d_w_stb  = 1'b1;
                d_w_data = $urandom;
                dimg[i*W +: W] = d_w_data;
                if (i == DNI - 1) d_img_q.push_back(dimg);
                tick();
            end
            d_w_stb = 1'b0;
            check("d_image_valid_pulse", d_image_valid, 1);
            check("d_busy", d_busy, 1);
            tick();
            for (int k = 0; k < DNO; k++) begin
                logic [W-1:0] rw;
                rw = $urandom;
                d_result[k*W +: W] = rw;
                d_rd_q.push_back(rw);
            end
            d_result_valid = 1'b1;
            tick();
            d_result_valid = 1'b0;
            d_r_stb = 1'b1;
            pops = 0;
            cyc  = 0;
            while (pops < DNO && cyc < 500) begin
                if (d_r_valid) pops++;
                tick();
                cyc++;
            end
            d_r_stb = 1'b0;
            if (pops < DNO) begin
                checks++; errors++;
                $display("FAIL d_drain_timeout: got %0d pops, expected %0d", pops, DNO);
            end
            check("d_w_ready_after_drain", d_w_ready, 1);
        end
        check("d_pulse_count", d_pulses_seen, 2);
        check("d_rd_q_empty", d_rd_q.size(), 0);
        check("d_overflow", d_overflow, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
